motion_detect_pipe: RTL and testbench
=====================================

Name: motion_detect_pipe

Overview:
Parametrised successor to the single-pixel motion pipeline. It streams pixels with valid/ready handshakes and compares each live pixel against its background pixel in grayscale. Motion pixels are replaced by a highlight colour, and the block counts motion pixels per frame. It sits between the frame reader/background memory and the display/output writer, and drives the background write-back port.

Parameters:
WIDTH_BITS, 11, frame width counter bits
HEIGHT_BITS, 10, frame height counter bits
CNT_BITS, 21, motion counter width; saturates at all-ones
HL_COLOR, 32'h00FF0000, value substituted for motion pixels

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
enable  in  1  1 = accept new input; 0 = block input, drain in-flight pixels
in_valid  in  1  input pixel pair valid
in_ready  out  1  input accepted when in_valid&in_ready
rbg_pixel  in  32  live pixel; [23:16]=R [15:8]=G [7:0]=B, [31:24] unused
memory_pixel  in  32  background pixel, same layout
wr_background  in  1  write live pixel back to background memory
last_in_frame  in  1  upstream end-of-frame marker
threshold  in  8  motion threshold
width  in  WIDTH_BITS  frame width, legal range 1..2^WIDTH_BITS-1
height  in  HEIGHT_BITS  frame height, legal range 1..2^HEIGHT_BITS-1
highlighted_pixel  out  32  output pixel
pixel_valid  out  1  output valid
pixel_ready  in  1  downstream ready
pixel_last  out  1  last pixel of frame (counter-derived)
bg_wr_en  out  1  background write strobe
bg_wr_data  out  32  background write data
motion_count  out  CNT_BITS  motion pixels in last completed frame
count_valid  out  1  1-cycle pulse when motion_count updates
frame_err  out  1  sticky last_in_frame/counter mismatch

Behaviour:
- Reset values: every output is 0, including in_ready. Counters, pipeline valids and frame_err are cleared. Reset mid-frame discards in-flight pixels; the next accepted pixel is x=0, y=0.
- Pipeline: 3 stages with one global advance signal: adv = ~pixel_valid | pixel_ready.
- in_ready = adv & enable.
- All stages shift together on adv. Bubbles are allowed. No pixel is lost or duplicated under stall.
- Latency: a pixel accepted in cycle N appears at the output in cycle N+3 when there is no stall.
- S1: gray_live = (R+2G+B)>>2 and gray_bg likewise. Use 10-bit intermediates; the result is 8 bits.
- S2: diff = |gray_live - gray_bg| (8 bits). motion = diff > threshold (strict). threshold=0 means any difference.
- S3: highlighted_pixel = motion ? HL_COLOR : rbg_pixel.
- Sideband carried with each pixel: live pixel, wr_background, last flag.
- Coordinates: x and y update on input accept.
  - x wraps at width-1, then y increments.
  - cnt_last = (x==width-1)&&(y==height-1).
  - On cnt_last both counters clear. width and height are sampled on the first pixel of each frame.
- last_in_frame check: if last_in_frame != cnt_last on an accepted pixel, frame_err is set (sticky until reset).
  - If last_in_frame=1, counters clear regardless, realigning to upstream.
  - pixel_last follows cnt_last OR last_in_frame for that pixel.
- Background: bg_wr_en=1 and bg_wr_data=live pixel in the cycle a pixel with wr_background=1 handshakes at the output. Otherwise bg_wr_en=0.
- Counting: the motion counter increments on output handshake of a motion pixel, saturating.
  - On output handshake with pixel_last, motion_count is loaded with the final count including that pixel.
  - count_valid pulses one cycle and the internal counter clears.
  - A motion pixel and frame end in the same cycle are both counted.
- enable=0: counters hold; pixels already accepted drain normally.

Optional Feature:
MP_BBOX_EN
- Defined: adds outputs bbox_xmin, bbox_xmax (WIDTH_BITS) and bbox_ymin, bbox_ymax (HEIGHT_BITS).
  - Each pixel carries its coordinates through the pipeline.
  - The min/max of motion-pixel coordinates is tracked.
  - The box is latched with motion_count and the trackers reset on count_valid.
  - A frame with no motion reports all four values as 0 (identified by motion_count=0).
- Undefined: these ports and the coordinate sideband do not exist.

Test Plan:
1. Highlight: width=4, height=2, threshold=10; bg all 0x00101010, live equal except pixel 5 = 0x00FFFFFF (gray 255 vs 16) -> only output 5 = 0x00FF0000; pixel_last on output 8; motion_count=1; count_valid pulse; frame_err=0.
2. Latency: single pixel, pixel_ready=1 -> pixel_valid exactly 3 cycles after accept; in_ready stays 1.
3. Threshold edge: bg 0x001E1E1E (gray 30), threshold=10; live 0x00141414 (diff 10) -> passthrough; live 0x00131313 (diff 11) -> HL_COLOR.
4. Backpressure: pixel_ready=0 for 5 cycles mid-frame -> in_ready=0, outputs held stable, order preserved, 8 outputs total, counts correct.
5. Frame error: width=4, height=2, last_in_frame on pixel 3 -> frame_err=1, pixel_last on output 3; the next frame counts from x=0 with correct pixel_last on its 8th pixel.
6. Reset/background: wr_background=1 on all pixels -> bg_wr_en aligned with output handshakes, bg_wr_data=live pixel; rst low mid-frame -> all outputs 0 immediately; the next frame restarts at x=0 (bbox checks when MP_BBOX_EN is defined: motion at (1,0),(3,1) -> box 1..3 by 0..1).

Source files
------------

// File: rtl/motion_detect_pipe.sv
// Three-stage valid/ready motion highlighter with per-frame motion pixel counting.
// Define MP_BBOX_EN to add a per-frame bounding box of motion pixel coordinates.
module motion_detect_pipe #(
   parameter int          WIDTH_BITS  = 11,
   parameter int          HEIGHT_BITS = 10,
   parameter int          CNT_BITS    = 21,
   parameter logic [31:0] HL_COLOR    = 32'h00FF0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            rbg_pixel,
   input  logic [31:0]            memory_pixel,
   input  logic                   wr_background,
   input  logic                   last_in_frame,
   input  logic [7:0]             threshold,
   input  logic [WIDTH_BITS-1:0]  width,
   input  logic [HEIGHT_BITS-1:0] height,
   output logic [31:0]            highlighted_pixel,
   output logic                   pixel_valid,
   input  logic                   pixel_ready,
   output logic                   pixel_last,
   output logic                   bg_wr_en,
   output logic [31:0]            bg_wr_data,
   output logic [CNT_BITS-1:0]    motion_count,
   output logic                   count_valid,
`ifdef MP_BBOX_EN
   output logic [WIDTH_BITS-1:0]  bbox_xmin,
   output logic [WIDTH_BITS-1:0]  bbox_xmax,
   output logic [HEIGHT_BITS-1:0] bbox_ymin,
   output logic [HEIGHT_BITS-1:0] bbox_ymax,
`endif
   output logic                   frame_err
);

   localparam logic [WIDTH_BITS-1:0]  X_ONE = WIDTH_BITS'(1);
   localparam logic [HEIGHT_BITS-1:0] Y_ONE = HEIGHT_BITS'(1);
   localparam logic [CNT_BITS-1:0]    C_ONE = CNT_BITS'(1);

   function automatic logic [7:0] gray8(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
      logic [9:0] sum;
      sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
      return 8'(sum >> 2);
   endfunction

   function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
      logic signed [9:0] d;
      d = $signed({2'b00, a}) - $signed({2'b00, b});
      return d[9] ? 8'(-d) : 8'(d);
   endfunction

   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
      return (&c) ? c : c + C_ONE;
   endfunction

   logic                   run, adv, accept, out_hs;
   logic                   vld_p1, vld_p2, vld_p3;
   logic [7:0]             gray_live_p1, gray_bg_p1;
   logic [31:0]            pix_p1, pix_p2, pix_p3;
   logic                   wr_p1, wr_p2, wr_p3;
   logic                   last_p1, last_p2, last_p3;
   logic                   motion_p2, motion_p3;
   logic [WIDTH_BITS-1:0]  x, w_cur, w_eff;
   logic [HEIGHT_BITS-1:0] y, h_cur, h_eff;
   logic                   sof, x_end, cnt_last;
   logic [CNT_BITS-1:0]    cnt, cnt_inc;
   logic                   unused_bg_bits;

   // run keeps in_ready low while reset is asserted, even though adv is high then
   assign adv      = ~vld_p3 | pixel_ready;
   assign in_ready = adv & enable & run;
   assign accept   = in_valid & in_ready;
   assign out_hs   = vld_p3 & pixel_ready;

   assign pixel_valid       = vld_p3;
   assign pixel_last        = vld_p3 & last_p3;
   assign highlighted_pixel = vld_p3 ? (motion_p3 ? HL_COLOR : pix_p3) : '0;
   assign bg_wr_en          = out_hs & wr_p3;
   assign bg_wr_data        = bg_wr_en ? pix_p3 : '0;
   assign unused_bg_bits    = ^memory_pixel[31:24];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run    <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
      end else begin
         run <= 1'b1;
         if (adv) begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         // stage 1: grayscale of live and background pixels
         gray_live_p1 <= gray8(rbg_pixel[23:16], rbg_pixel[15:8], rbg_pixel[7:0]);
         gray_bg_p1   <= gray8(memory_pixel[23:16], memory_pixel[15:8], memory_pixel[7:0]);
         pix_p1       <= rbg_pixel;
         wr_p1        <= wr_background;
         last_p1      <= cnt_last | last_in_frame;
         // stage 2: absolute difference against threshold
         motion_p2    <= abs_diff(gray_live_p1, gray_bg_p1) > threshold;
         pix_p2       <= pix_p1;
         wr_p2        <= wr_p1;
         last_p2      <= last_p1;
         // stage 3: output select operands
         motion_p3    <= motion_p2;
         pix_p3       <= pix_p2;
         wr_p3        <= wr_p2;
         last_p3      <= last_p2;
      end
   end

   // Frame geometry is taken live on the first pixel, then held for the frame
   assign w_eff    = sof ? width : w_cur;
   assign h_eff    = sof ? height : h_cur;
   assign x_end    = (x == w_eff - X_ONE);
   assign cnt_last = x_end && (y == h_eff - Y_ONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x         <= '0;
         y         <= '0;
         w_cur     <= '0;
         h_cur     <= '0;
         sof       <= 1'b1;
         frame_err <= 1'b0;
      end else if (accept) begin
         if (sof) begin
            w_cur <= width;
            h_cur <= height;
         end
         if (last_in_frame != cnt_last) frame_err <= 1'b1;
         if (cnt_last || last_in_frame) begin
            x   <= '0;
            y   <= '0;
            sof <= 1'b1;
         end else begin
            sof <= 1'b0;
            if (x_end) begin
               x <= '0;
               y <= y + Y_ONE;
            end else begin
               x <= x + X_ONE;
            end
         end
      end
   end

   assign cnt_inc = motion_p3 ? sat_inc(cnt) : cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt          <= '0;
         motion_count <= '0;
         count_valid  <= 1'b0;
      end else begin
         count_valid <= 1'b0;
         if (out_hs) begin
            if (last_p3) begin
               motion_count <= cnt_inc;
               count_valid  <= 1'b1;
               cnt          <= '0;
            end else begin
               cnt <= cnt_inc;
            end
         end
      end
   end

`ifdef MP_BBOX_EN
   logic [WIDTH_BITS-1:0]  x_p1, x_p2, x_p3, bx_min, bx_max, nx_min, nx_max;
   logic [HEIGHT_BITS-1:0] y_p1, y_p2, y_p3, by_min, by_max, ny_min, ny_max;
   logic                   b_any, nb_any, hit;

   always_ff @(posedge clk) begin
      if (adv) begin
         x_p1 <= x;
         y_p1 <= y;
         x_p2 <= x_p1;
         y_p2 <= y_p1;
         x_p3 <= x_p2;
         y_p3 <= y_p2;
      end
   end

   assign hit = out_hs & motion_p3;

   always_comb begin
      nx_min = bx_min;
      nx_max = bx_max;
      ny_min = by_min;
      ny_max = by_max;
      nb_any = b_any;
      if (hit) begin
         if (!b_any || x_p3 < bx_min) nx_min = x_p3;
         if (!b_any || x_p3 > bx_max) nx_max = x_p3;
         if (!b_any || y_p3 < by_min) ny_min = y_p3;
         if (!b_any || y_p3 > by_max) ny_max = y_p3;
         nb_any = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bx_min    <= '0;
         bx_max    <= '0;
         by_min    <= '0;
         by_max    <= '0;
         b_any     <= 1'b0;
         bbox_xmin <= '0;
         bbox_xmax <= '0;
         bbox_ymin <= '0;
         bbox_ymax <= '0;
      end else if (out_hs) begin
         if (last_p3) begin
            bbox_xmin <= nb_any ? nx_min : '0;
            bbox_xmax <= nb_any ? nx_max : '0;
            bbox_ymin <= nb_any ? ny_min : '0;
            bbox_ymax <= nb_any ? ny_max : '0;
            bx_min    <= '0;
            bx_max    <= '0;
            by_min    <= '0;
            by_max    <= '0;
            b_any     <= 1'b0;
         end else begin
            bx_min <= nx_min;
            bx_max <= nx_max;
            by_min <= ny_min;
            by_max <= ny_max;
            b_any  <= nb_any;
         end
      end
   end
`endif

endmodule

// File: tb/tb_motion_detect_pipe.sv
// Directed testbench for motion_detect_pipe: highlight, latency, threshold edge,
// backpressure, frame-marker mismatch, background write-back and mid-frame reset.
module tb_motion_detect_pipe;
   localparam int          WB = 11;
   localparam int          HB = 10;
   localparam int          CB = 21;
   localparam logic [31:0] HL = 32'h00FF0000;

   logic          clk = 1'b0, rst = 1'b0, enable = 1'b1, in_valid = 1'b0, in_ready;
   logic [31:0]   rbg_pixel = '0, memory_pixel = '0;
   logic          wr_background = 1'b0, last_in_frame = 1'b0;
   logic [7:0]    threshold = 8'd10;
   logic [WB-1:0] width = 11'd4;
   logic [HB-1:0] height = 10'd2;
   logic [31:0]   highlighted_pixel, bg_wr_data;
   logic          pixel_valid, pixel_ready = 1'b1, pixel_last, bg_wr_en, count_valid, frame_err;
   logic [CB-1:0] motion_count;
`ifdef MP_BBOX_EN
   logic [WB-1:0] bbox_xmin, bbox_xmax;
   logic [HB-1:0] bbox_ymin, bbox_ymax;
   logic [WB-1:0] bx0[16], bx1[16];
   logic [HB-1:0] by0[16], by1[16];
`endif

   int checks = 0, errors = 0, cyc = 0;
   logic [31:0] live_v[16], bg_v[16];
   logic        wr_v[16], last_v[16];
   logic [31:0] out_pix[128], out_bgd[128];
   logic        out_last[128], out_bgen[128];
   int          out_cyc[128], acc_cyc[16];
   logic [CB-1:0] cnt_vals[16];
   int n_out = 0, n_cnt = 0, bg_stray = 0;
   int stall_seen, stall_ir_bad, stall_chg, ir_drop;

   motion_detect_pipe #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CNT_BITS(CB), .HL_COLOR(HL)) dut (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
      .rbg_pixel(rbg_pixel), .memory_pixel(memory_pixel), .wr_background(wr_background),
      .last_in_frame(last_in_frame), .threshold(threshold), .width(width), .height(height),
      .highlighted_pixel(highlighted_pixel), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .pixel_last(pixel_last), .bg_wr_en(bg_wr_en), .bg_wr_data(bg_wr_data),
      .motion_count(motion_count), .count_valid(count_valid),
`ifdef MP_BBOX_EN
      .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
`endif
      .frame_err(frame_err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output capture: every handshake and every count pulse, in arrival order
   always @(negedge clk) begin
      if (pixel_valid && pixel_ready) begin
         if (n_out < 128) begin
            out_pix[n_out]  = highlighted_pixel;
            out_last[n_out] = pixel_last;
            out_bgen[n_out] = bg_wr_en;
            out_bgd[n_out]  = bg_wr_data;
            out_cyc[n_out]  = cyc;
         end
         n_out++;
      end else if (bg_wr_en) begin
         bg_stray++;
      end
      if (count_valid) begin
         if (n_cnt < 16) begin
            cnt_vals[n_cnt] = motion_count;
`ifdef MP_BBOX_EN
            bx0[n_cnt] = bbox_xmin; bx1[n_cnt] = bbox_xmax;
            by0[n_cnt] = bbox_ymin; by1[n_cnt] = bbox_ymax;
`endif
         end
         n_cnt++;
      end
   end

   task automatic set_frame(input logic [31:0] live, input logic [31:0] bg);
      for (int i = 0; i < 16; i++) begin
         live_v[i] = live; bg_v[i] = bg; wr_v[i] = 1'b0; last_v[i] = 1'b0;
      end
   endtask

   task automatic drive_frame(input int n, input int stall_at, input int stall_len, input int n_target);
      int idx, cnt, ob;
      logic acc, have_held;
      logic [31:0] held;
      idx = 0; cnt = 0; ob = n_out; have_held = 1'b0; held = '0;
      stall_seen = 0; stall_ir_bad = 0; stall_chg = 0; ir_drop = 0;
      @(posedge clk); #1;
      pixel_ready = 1'b1;
      in_valid = (n > 0);
      rbg_pixel = live_v[0]; memory_pixel = bg_v[0];
      wr_background = wr_v[0]; last_in_frame = last_v[0];
      while ((idx < n || (n_out - ob) < n_target) && cnt < 300) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) acc_cyc[idx] = cyc;
         if (pixel_ready && in_ready !== 1'b1) ir_drop++;
         if (!pixel_ready && pixel_valid) begin
            stall_seen++;
            if (in_ready !== 1'b0) stall_ir_bad++;
            if (!have_held) begin
               held = highlighted_pixel; have_held = 1'b1;
            end else if (highlighted_pixel !== held) begin
               stall_chg++;
            end
         end
         @(posedge clk); #1;
         if (acc) idx++;
         cnt++;
         pixel_ready = !(cnt >= stall_at && cnt < stall_at + stall_len);
         in_valid = (idx < n);
         if (idx < n) begin
            rbg_pixel = live_v[idx]; memory_pixel = bg_v[idx];
            wr_background = wr_v[idx]; last_in_frame = last_v[idx];
         end
      end
      in_valid = 1'b0; pixel_ready = 1'b1; wr_background = 1'b0; last_in_frame = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({in_ready, pixel_valid, pixel_last, bg_wr_en, count_valid, frame_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 000000",
                  {in_ready, pixel_valid, pixel_last, bg_wr_en, count_valid, frame_err});
      end
      checks++;
      if ({highlighted_pixel, bg_wr_data} !== 64'h0) begin
         errors++;
         $display("FAIL reset_data got %h %h want 0 0", highlighted_pixel, bg_wr_data);
      end
      checks++;
      if (motion_count !== '0) begin
         errors++; $display("FAIL reset_count got %0d want 0", motion_count);
      end
      @(posedge clk); #1; rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_highlight();
      int ob, cb, bs;
      logic [31:0] e;
      width = 11'd4; height = 10'd2; threshold = 8'd10;
      set_frame(32'h00101010, 32'h00101010);
      live_v[4] = 32'h00FFFFFF; last_v[7] = 1'b1;
      ob = n_out; cb = n_cnt; bs = bg_stray;
      drive_frame(8, 1000, 0, 8);
      repeat (3) @(negedge clk);
      checks++;
      if (n_out - ob !== 8) begin
         errors++; $display("FAIL hl_nout got %0d want 8", n_out - ob);
      end
      for (int i = 0; i < 8; i++) begin
         e = (i == 4) ? HL : 32'h00101010;
         checks++;
         if (out_pix[ob+i] !== e) begin
            errors++; $display("FAIL hl_pix[%0d] got %h want %h", i, out_pix[ob+i], e);
         end
         checks++;
         if (out_last[ob+i] !== (i == 7) || out_bgen[ob+i] !== 1'b0) begin
            errors++;
            $display("FAIL hl_last_bgen[%0d] got %b%b want %b0", i, out_last[ob+i], out_bgen[ob+i], i == 7);
         end
      end
      checks++;
      if (n_cnt - cb !== 1 || cnt_vals[cb] !== CB'(1)) begin
         errors++; $display("FAIL hl_count got %0d pulses value %0d want 1 pulse value 1", n_cnt - cb, cnt_vals[cb]);
      end
      checks++;
      if (frame_err !== 1'b0 || bg_stray !== bs) begin
         errors++; $display("FAIL hl_err_stray got %b %0d want 0 %0d", frame_err, bg_stray, bs);
      end
   endtask

   task automatic test_latency();
      int ob, cb;
      width = 11'd1; height = 10'd1;
      set_frame(32'h00101010, 32'h00101010);
      last_v[0] = 1'b1;
      ob = n_out; cb = n_cnt;
      drive_frame(1, 1000, 0, 1);
      repeat (3) @(negedge clk);
      checks++;
      if (out_cyc[ob] - acc_cyc[0] !== 3) begin
         errors++; $display("FAIL latency got %0d want 3", out_cyc[ob] - acc_cyc[0]);
      end
      checks++;
      if (ir_drop !== 0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL lat_in_ready got drops %0d now %b want 0 1", ir_drop, in_ready);
      end
      checks++;
      if (out_last[ob] !== 1'b1 || n_cnt - cb !== 1 || cnt_vals[cb] !== '0) begin
         errors++;
         $display("FAIL lat_frame got last %b pulses %0d count %0d want 1 1 0", out_last[ob], n_cnt - cb, cnt_vals[cb]);
      end
   endtask

   task automatic test_threshold();
      int ob, cb;
      width = 11'd2; height = 10'd1; threshold = 8'd10;
      set_frame(32'h00141414, 32'h001E1E1E);
      live_v[1] = 32'h00131313; last_v[1] = 1'b1;
      ob = n_out; cb = n_cnt;
      drive_frame(2, 1000, 0, 2);
      repeat (3) @(negedge clk);
      checks++;
      if (out_pix[ob] !== 32'h00141414) begin
         errors++; $display("FAIL thr_diff10 got %h want 00141414", out_pix[ob]);
      end
      checks++;
      if (out_pix[ob+1] !== HL) begin
         errors++; $display("FAIL thr_diff11 got %h want %h", out_pix[ob+1], HL);
      end
      checks++;
      if ({out_last[ob], out_last[ob+1]} !== 2'b01 || cnt_vals[cb] !== CB'(1) || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL thr_frame got last %b%b count %0d err %b want 01 1 0",
                  out_last[ob], out_last[ob+1], cnt_vals[cb], frame_err);
      end
   endtask

   task automatic test_backpressure();
      int ob, cb;
      logic [31:0] e;
      width = 11'd4; height = 10'd2; threshold = 8'd10;
      set_frame(32'h00101010, 32'h00101010);
      for (int i = 0; i < 8; i++) live_v[i] = 32'h00101010 + 32'(i);
      live_v[2] = 32'h00FFFFFF; live_v[6] = 32'h00FFFFFF; last_v[7] = 1'b1;
      ob = n_out; cb = n_cnt;
      drive_frame(8, 5, 5, 8);
      repeat (3) @(negedge clk);
      checks++;
      if (stall_seen !== 5 || stall_ir_bad !== 0 || stall_chg !== 0) begin
         errors++;
         $display("FAIL bp_stall got seen %0d ir_bad %0d changed %0d want 5 0 0", stall_seen, stall_ir_bad, stall_chg);
      end
      checks++;
      if (n_out - ob !== 8) begin
         errors++; $display("FAIL bp_nout got %0d want 8", n_out - ob);
      end
      for (int i = 0; i < 8; i++) begin
         e = (i == 2 || i == 6) ? HL : 32'h00101010 + 32'(i);
         checks++;
         if (out_pix[ob+i] !== e || out_last[ob+i] !== (i == 7)) begin
            errors++;
            $display("FAIL bp_out[%0d] got %h last %b want %h last %b", i, out_pix[ob+i], out_last[ob+i], e, i == 7);
         end
      end
      checks++;
      if (n_cnt - cb !== 1 || cnt_vals[cb] !== CB'(2) || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL bp_count got %0d pulses value %0d err %b want 1 2 0", n_cnt - cb, cnt_vals[cb], frame_err);
      end
   endtask

   task automatic test_frame_err();
      int ob, cb;
      width = 11'd4; height = 10'd2;
      set_frame(32'h00101010, 32'h00101010);
      for (int i = 0; i < 11; i++) live_v[i] = 32'h00101010 + 32'(i % 4);
      last_v[2] = 1'b1;
      ob = n_out; cb = n_cnt;
      drive_frame(11, 1000, 0, 11);
      repeat (3) @(negedge clk);
      checks++;
      if (frame_err !== 1'b1) begin
         errors++; $display("FAIL ferr_flag got %b want 1", frame_err);
      end
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (out_last[ob+i] !== (i == 2 || i == 10)) begin
            errors++;
            $display("FAIL ferr_last[%0d] got %b want %b", i, out_last[ob+i], (i == 2 || i == 10));
         end
      end
      checks++;
      if (n_cnt - cb !== 2 || cnt_vals[cb] !== '0 || cnt_vals[cb+1] !== '0) begin
         errors++;
         $display("FAIL ferr_counts got %0d pulses %0d %0d want 2 0 0", n_cnt - cb, cnt_vals[cb], cnt_vals[cb+1]);
      end
   endtask

   task automatic test_reset_background();
      int ob, cb, bs;
      logic [31:0] e;
      @(posedge clk); #1; rst = 1'b0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b1;
      checks++;
      if (frame_err !== 1'b0) begin
         errors++; $display("FAIL rb_err_clear got %b want 0", frame_err);
      end
      width = 11'd4; height = 10'd2; threshold = 8'd10;
      set_frame(32'h00101010, 32'h00101010);
      for (int i = 0; i < 8; i++) begin
         live_v[i] = 32'h00101010 + 32'(i); wr_v[i] = 1'b1;
      end
      live_v[1] = 32'h00FFFFFF; live_v[7] = 32'h00FFFFFF; last_v[7] = 1'b1;
      ob = n_out; cb = n_cnt; bs = bg_stray;
      drive_frame(8, 1000, 0, 8);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         e = (i == 1 || i == 7) ? HL : live_v[i];
         checks++;
         if (out_bgen[ob+i] !== 1'b1 || out_bgd[ob+i] !== live_v[i] || out_pix[ob+i] !== e) begin
            errors++;
            $display("FAIL rb_bg[%0d] got en %b data %h pix %h want 1 %h %h",
                     i, out_bgen[ob+i], out_bgd[ob+i], out_pix[ob+i], live_v[i], e);
         end
      end
      checks++;
      if (bg_stray !== bs || n_cnt - cb !== 1 || cnt_vals[cb] !== CB'(2)) begin
         errors++;
         $display("FAIL rb_count got stray %0d pulses %0d value %0d want %0d 1 2", bg_stray, n_cnt - cb, cnt_vals[cb], bs);
      end
`ifdef MP_BBOX_EN
      checks++;
      if (bx0[cb] !== WB'(1) || bx1[cb] !== WB'(3) || by0[cb] !== HB'(0) || by1[cb] !== HB'(1)) begin
         errors++;
         $display("FAIL rb_bbox got %0d..%0d x %0d..%0d want 1..3 x 0..1", bx0[cb], bx1[cb], by0[cb], by1[cb]);
      end
`endif
      // Part-fill the pipeline, then drop reset asynchronously mid-frame
      drive_frame(3, 1000, 0, 0);
      @(posedge clk); #2; rst = 1'b0; #1;
      checks++;
      if ({in_ready, pixel_valid, pixel_last, bg_wr_en, count_valid, frame_err} !== 6'b0 ||
          {highlighted_pixel, bg_wr_data} !== 64'h0 || motion_count !== '0) begin
         errors++;
         $display("FAIL rb_async_reset got ctrl %b pix %h bg %h cnt %0d want all 0",
                  {in_ready, pixel_valid, pixel_last, bg_wr_en, count_valid, frame_err},
                  highlighted_pixel, bg_wr_data, motion_count);
      end
      repeat (2) @(negedge clk);
      @(posedge clk); #1; rst = 1'b1;
      set_frame(32'h00101010, 32'h00101010);
      last_v[7] = 1'b1;
      ob = n_out; cb = n_cnt;
      drive_frame(8, 1000, 0, 8);
      repeat (3) @(negedge clk);
      checks++;
      if (n_out - ob !== 8) begin
         errors++; $display("FAIL rb_restart_nout got %0d want 8", n_out - ob);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_last[ob+i] !== (i == 7)) begin
            errors++; $display("FAIL rb_restart_last[%0d] got %b want %b", i, out_last[ob+i], i == 7);
         end
      end
      checks++;
      if (frame_err !== 1'b0 || n_cnt - cb !== 1 || cnt_vals[cb] !== '0) begin
         errors++;
         $display("FAIL rb_restart_frame got err %b pulses %0d count %0d want 0 1 0", frame_err, n_cnt - cb, cnt_vals[cb]);
      end
   endtask

   initial begin
      test_reset();
      test_highlight();
      test_latency();
      test_threshold();
      test_backpressure();
      test_frame_err();
      test_reset_background();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
